fnd_display_scheduler: RTL and testbench
========================================

FND_DISPLAY_SCHEDULER -- requirements
Module: fnd_display_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, digit scan tick rate in Hz; CLK_HZ/SCAN_HZ SHALL be an integer of at least 2.
REQ-003 Parameter DWELL_FRAMES, default 500, number of frames each source is shown in auto rotation (one frame is 4 ticks).
REQ-004 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  3  per-source one-cycle pulse meaning "fresh data, show me"; bit k belongs to source k.
REQ-007 auto_en  in  1  1 = auto rotation with preemption; 0 = manual selection.
REQ-008 man_sel  in  2  source shown when auto_en=0; value 3 means blank.
REQ-009 val0, val1, val2  in  14 each  binary display values for sources 0 (stopwatch), 1 (DHT11), 2 (SR04); legal range 0..9999.
REQ-010 fnd_com  out  4  active-low one-hot digit enable.
REQ-011 digit_sel  out  2  current scan digit index; 0 is the least significant digit.
REQ-012 bcd  out  4  nibble for the current digit: 0-9, 4'hF = blank, 4'hE = error.
REQ-013 src_id  out  2  source owning the current frame.
REQ-014 frame_done  out  1  one-cycle pulse on every frame boundary.

Function
REQ-015 Tick: a counter SHALL pulse an internal tick every CLK_HZ/SCAN_HZ clocks.
REQ-016 Scan: digit_sel SHALL increment modulo 4 on each tick; fnd_com SHALL equal ~(1<<digit_sel).
REQ-017 Output timing: fnd_com, digit_sel and bcd are registered and SHALL update on the clock edge after the tick.
REQ-018 Frame boundary: the tick at which digit_sel wraps from 3 to 0. On that tick frame_done SHALL pulse with the same timing as REQ-017.
REQ-019 Source and snapshot update only at frame boundaries: src_id is updated and the selected val is latched into a 14-bit snapshot. bcd SHALL derive only from the snapshot, so there is no tearing within a frame.
REQ-020 Digits: digit n = (snapshot / 10^n) % 10. If snapshot > 9999, every digit SHALL be 4'hE.
REQ-021 State machine states:
  - IDLE: entered on reset.
  - AUTO: active when auto_en=1.
  - MANUAL: active when auto_en=0.
  - Transitions out of IDLE, and any auto_en change, SHALL take effect only at a frame boundary.
REQ-022 Pending: req[k] SHALL set pending[k] in any state, except when k equals src_id in AUTO, where it restarts the dwell count instead.
REQ-023 AUTO dwell: a frame counter increments each frame boundary. At count DWELL_FRAMES-1 with no pending bit set, src_id SHALL advance 0→1→2→0 and the counter SHALL clear.
REQ-024 AUTO preempt: at a frame boundary with any pending bit set, src_id SHALL become the lowest-index pending source. That pending bit SHALL be cleared and the dwell counter cleared. Preempt SHALL win over dwell expiry in the same frame.
REQ-025 Simultaneous events: a req arriving on the same clock as its pending bit is cleared SHALL leave the bit set.
REQ-026 MANUAL: src_id SHALL equal man_sel at each boundary and the dwell counter SHALL hold at 0. Pending bits are retained. man_sel=3 SHALL force bcd=4'hF on all digits.
REQ-027 On entering AUTO from MANUAL, src_id SHALL start from the current man_sel, or from 0 if man_sel=3.

Reset
REQ-028 While rst=0, the block SHALL hold: fnd_com=4'b1111, digit_sel=0, bcd=4'hF, src_id=0, frame_done=0, snapshot=0, pending=0, dwell=0, tick counter=0, state IDLE.
REQ-029 Reset asserted mid-frame SHALL abort immediately with no further frame_done. The first frame after release SHALL begin on the first tick.
REQ-030 Outputs from IDLE SHALL remain at reset values until the first frame boundary after release.

Configuration
REQ-031 Macro FND_LZ_BLANK_EN:
  - Defined: digits 3..1 SHALL output 4'hF when they and all higher digits are zero; digit 0 is always shown; error 4'hE is not blanked.
  - Undefined: all four digits SHALL show their decimal value, including leading zeros.

Verification (CLK_HZ=40, SCAN_HZ=10, DWELL_FRAMES=3: tick every 4 clocks, frame every 16 clocks)
REQ-032 Reset release, auto_en=1, val0=1234 → first frame_done at clock 16, src_id=0; next frame shows bcd 4,3,2,1 with fnd_com 1110,1101,1011,0111.
REQ-033 auto_en=1, no req → src_id sequence 0,1,2,0 changing every 3 frames (48 clocks).
REQ-034 src_id=0, req=3'b110 pulsed in the same cycle → next boundary src_id=1, following boundary src_id=2 (pending[2] served), dwell restarted each time.
REQ-035 val1=12345, src_id=1 → all digits 4'hE. With FND_LZ_BLANK_EN and val0=7 → bcd 7,F,F,F; without the macro → 7,0,0,0.
REQ-036 auto_en=0, man_sel=3 mid-frame → the current frame completes unchanged, then bcd=4'hF on all digits. Assert rst=0 mid-frame → fnd_com=1111 at once.

Source files
------------

// File: rtl/fnd_display_scheduler.sv
// Four-digit FND scan scheduler: rotates or manually selects one of three value sources per frame.
// Optional FND_LZ_BLANK_EN blanks leading zeros on digits 3..1.
module fnd_display_scheduler #(
  parameter int CLK_HZ       = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int DWELL_FRAMES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic        auto_en,
  input  logic [1:0]  man_sel,
  input  logic [13:0] val0,
  input  logic [13:0] val1,
  input  logic [13:0] val2,
  output logic [3:0]  fnd_com,
  output logic [1:0]  digit_sel,
  output logic [3:0]  bcd,
  output logic [1:0]  src_id,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int TW  = $clog2(DIV);
  localparam int DW  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTO   = 2'd1,
    ST_MANUAL = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [TW-1:0] tick_cnt_r;
  logic [1:0]    scan_r, scan_nxt_s, src_nxt_s, low_s;
  logic [DW-1:0] dwell_r, dwell_nxt_s;
  logic [2:0]    pend_r, pend_nxt_s, own_s, clr_s;
  logic [13:0]   snap_r, snap_nxt_s, sel_val_s;
  logic          tick_s, boundary_s, own_req_s;

  // Decimal digit n of v; out-of-range values show error on every digit.
  function automatic logic [3:0] digit_of(input logic [13:0] v, input logic [1:0] n);
    logic [13:0] pw;
    case (n)
      2'd0:    pw = 14'd1;
      2'd1:    pw = 14'd10;
      2'd2:    pw = 14'd100;
      default: pw = 14'd1000;
    endcase
    if (v > 14'd9999) begin
      digit_of = 4'hE;
`ifdef FND_LZ_BLANK_EN
    end else if ((n != 2'd0) && (v < pw)) begin
      digit_of = 4'hF;
`endif
    end else begin
      digit_of = 4'((v / pw) % 14'd10);
    end
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [2:0] p);
    if (p[0]) begin
      lowest_idx = 2'd0;
    end else if (p[1]) begin
      lowest_idx = 2'd1;
    end else begin
      lowest_idx = 2'd2;
    end
  endfunction

  // Next-frame scheduling decisions; only committed on a frame boundary.
  always_comb begin
    tick_s      = (tick_cnt_r == TW'(DIV - 1));
    boundary_s  = tick_s && (scan_r == 2'd3);
    scan_nxt_s  = scan_r + 2'd1;
    own_s       = (state_r == ST_AUTO) ? (3'b001 << src_id) : 3'b000;
    own_req_s   = |(req & own_s);
    low_s       = lowest_idx(pend_r);
    clr_s       = 3'b000;
    state_nxt_s = state_r;
    src_nxt_s   = src_id;
    dwell_nxt_s = own_req_s ? '0 : dwell_r;
    if (boundary_s) begin
      state_nxt_s = auto_en ? ST_AUTO : ST_MANUAL;
      if (!auto_en) begin
        src_nxt_s   = man_sel;
        dwell_nxt_s = '0;
      end else if (state_r != ST_AUTO) begin
        src_nxt_s   = ((state_r == ST_MANUAL) && (man_sel != 2'd3)) ? man_sel : 2'd0;
        dwell_nxt_s = '0;
      end else if (|pend_r) begin
        src_nxt_s   = low_s;
        clr_s       = 3'b001 << low_s;
        dwell_nxt_s = '0;
      end else if (own_req_s) begin
        dwell_nxt_s = '0;
      end else if (dwell_r == DW'(DWELL_FRAMES - 1)) begin
        src_nxt_s   = (src_id == 2'd2) ? 2'd0 : src_id + 2'd1;
        dwell_nxt_s = '0;
      end else begin
        dwell_nxt_s = dwell_r + DW'(1);
      end
    end else begin
      clr_s = 3'b000;
    end
    // a req landing on the clearing clock wins over the clear
    pend_nxt_s = (pend_r & ~clr_s) | (req & ~own_s);
    case (src_nxt_s)
      2'd0:    sel_val_s = val0;
      2'd1:    sel_val_s = val1;
      2'd2:    sel_val_s = val2;
      default: sel_val_s = 14'd0;
    endcase
    snap_nxt_s = boundary_s ? sel_val_s : snap_r;
  end

  // Scheduler state and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= '0;
      scan_r     <= 2'd0;
      state_r    <= ST_IDLE;
      dwell_r    <= '0;
      pend_r     <= 3'b000;
      snap_r     <= 14'd0;
      src_id     <= 2'd0;
      fnd_com    <= 4'b1111;
      digit_sel  <= 2'd0;
      bcd        <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
      pend_r     <= pend_nxt_s;
      dwell_r    <= dwell_nxt_s;
      frame_done <= boundary_s;
      if (tick_s) begin
        scan_r <= scan_nxt_s;
      end
      if (boundary_s) begin
        state_r <= state_nxt_s;
        src_id  <= src_nxt_s;
        snap_r  <= snap_nxt_s;
      end
      // IDLE keeps the reset-valued outputs until the first boundary
      if (tick_s && (state_nxt_s != ST_IDLE)) begin
        digit_sel <= scan_nxt_s;
        fnd_com   <= ~(4'b0001 << scan_nxt_s);
        bcd       <= (src_nxt_s == 2'd3) ? 4'hF : digit_of(snap_nxt_s, scan_nxt_s);
      end
    end
  end

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Scoreboard bench for fnd_display_scheduler: frame-level reference model feeds a queue,
// a negedge monitor pops one expected frame per frame_done and checks every digit.
module tb_fnd_display_scheduler;

  localparam int FRAME = 16;
  localparam int DWELL = 3;

  logic        clk, rst, auto_en, frame_done;
  logic [2:0]  req;
  logic [1:0]  man_sel, digit_sel, src_id;
  logic [13:0] val0, val1, val2;
  logic [3:0]  fnd_com, bcd;

  fnd_display_scheduler #(.CLK_HZ(40), .SCAN_HZ(10), .DWELL_FRAMES(DWELL)) dut (
    .clk(clk), .rst(rst), .req(req), .auto_en(auto_en), .man_sel(man_sel),
    .val0(val0), .val1(val1), .val2(val2), .fnd_com(fnd_com), .digit_sel(digit_sel),
    .bcd(bcd), .src_id(src_id), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   m_n = 0, m_mode = 0, m_src = 0, m_dwell = 0, m_snap = 0;
  bit [2:0] m_pend = 3'b000;
  bit   has_cur = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, m_n);
    end
  endtask

  function automatic logic [3:0] exp_digit(input int src, input int v, input int n);
    int p;
    p = 10 ** n;
    if (src == 3) return 4'hF;
    if (v > 9999) return 4'hE;
`ifdef FND_LZ_BLANK_EN
    if (n > 0 && v < p) return 4'hF;
`endif
    return 4'((v / p) % 10);
  endfunction

  // Reference model: frame decisions from the scheduling rules, one expected frame per boundary.
  always @(posedge clk) begin
    int own;
    int k;
    exp_t e;
    if (!rst) begin
      m_n = 0; m_mode = 0; m_src = 0; m_dwell = 0; m_pend = 3'b000; m_snap = 0;
      exp_q.delete();
    end else begin
      own = (m_mode == 1) ? m_src : -1;
      m_n++;
      if (m_n % FRAME == 0) begin
        if (!auto_en) begin
          m_mode = 2; m_src = int'(man_sel); m_dwell = 0;
        end else if (m_mode != 1) begin
          m_src = (m_mode == 2 && man_sel != 2'd3) ? int'(man_sel) : 0;
          m_mode = 1; m_dwell = 0;
        end else if (m_pend != 3'b000) begin
          k = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
          m_src = k; m_pend[k] = 1'b0; m_dwell = 0;
        end else if (req[own]) begin
          m_dwell = 0;
        end else if (m_dwell == DWELL - 1) begin
          m_src = (m_src + 1) % 3; m_dwell = 0;
        end else begin
          m_dwell++;
        end
        m_snap = (m_src == 0) ? int'(val0) : (m_src == 1) ? int'(val1) : (m_src == 2) ? int'(val2) : 0;
        e.src = 2'(m_src);
        for (int i = 0; i < 4; i++) e.d[i*4 +: 4] = exp_digit(m_src, m_snap, i);
        exp_q.push_back(e);
      end else if (own >= 0 && req[own]) begin
        m_dwell = 0;
      end
      for (int j = 0; j < 3; j++) if (req[j] && j != own) m_pend[j] = 1'b1;
    end
  end

  // Monitor: frame_done timing, frame contents per digit, and reset/idle output values.
  always @(negedge clk) begin
    int idx;
    bit exp_fd;
    if (!rst) begin
      has_cur = 1'b0;
      chk("rst_fnd_com", fnd_com, 15);
      chk("rst_digit_sel", digit_sel, 0);
      chk("rst_bcd", bcd, 15);
      chk("rst_src_id", src_id, 0);
      chk("rst_frame_done", frame_done, 0);
    end else begin
      exp_fd = (m_n >= FRAME) && (m_n % FRAME == 0);
      chk("frame_done", frame_done, exp_fd);
      if (exp_fd) begin
        chk("exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          has_cur = 1'b1;
        end else begin
          has_cur = 1'b0;
        end
      end
      if (m_n > 0 && m_n % 4 == 0) begin
        if (m_n < FRAME) begin
          chk("idle_fnd_com", fnd_com, 15);
          chk("idle_bcd", bcd, 15);
          chk("idle_digit_sel", digit_sel, 0);
          chk("idle_src_id", src_id, 0);
        end else if (has_cur) begin
          idx = (m_n % FRAME) / 4;
          chk("src_id", src_id, cur.src);
          chk("digit_sel", digit_sel, idx);
          chk("fnd_com", fnd_com, (~(1 << idx)) & 15);
          chk("bcd", bcd, cur.d[idx*4 +: 4]);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] r);
    @(negedge clk) req = r;
    @(negedge clk) req = 3'b000;
  endtask

  initial begin
    rst = 1'b0; req = 3'b000; auto_en = 1'b1; man_sel = 2'd0;
    val0 = 14'd1234; val1 = 14'd12345; val2 = 14'd42;
    run(3);
    #2 rst = 1'b1;
    // preempt with two pending sources while source 0 is shown
    run(20);
    pulse(3'b110);
    run(140);
    val0 = 14'd7;
    run(200);
    // manual blank requested mid-frame, then a real manual source
    run(5);
    auto_en = 1'b0; man_sel = 2'd3;
    run(64);
    man_sel = 2'd2;
    run(48);
    pulse(3'b001);
    auto_en = 1'b1; man_sel = 2'd1;
    run(100);
    auto_en = 1'b0; man_sel = 2'd3;
    run(40);
    auto_en = 1'b1;
    run(60);
    // asynchronous reset in the middle of a frame
    for (int i = 0; i < 20 && (m_n % FRAME) != 7; i++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_fnd_com", fnd_com, 15);
    chk("async_rst_frame_done", frame_done, 0);
    run(3);
    #2 rst = 1'b1;
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 99) == 0) man_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) val0 = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 49) == 0) val1 = 14'($urandom_range(0, 120));
      if ($urandom_range(0, 49) == 0) val2 = 14'($urandom_range(0, 10050));
    end
    req = 3'b000;
    run(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
